bist_ctrl: RTL
==============

# bist_ctrl

Built-in self-test sequencer for one SRAM port. It runs up to NUM_PATTERNS deterministic pattern generators (det_patgen_if slaves such as the March CM-enhanced generator) back to back. While a test runs it takes the SRAM port away from the functional user and compares read data against each generator's `check` value after the macro's read latency. When the sequence ends it reports pass/fail, the first failing pattern and address, and a saturating mismatch count. It sits between the functional port logic, the pattern generators and the SRAM macro.

## Interface
- ADDR_WIDTH, 6, SRAM address width
- DATA_WIDTH, 8, SRAM data width
- MASK_WIDTH, 2, write-mask width
- NUM_PATTERNS, 3, number of attached pattern generators (>=1)
- READ_LATENCY, 1, cycles from `sram_re` to valid `sram_dout` (>=1)

- clk  in  1  clock; all logic on rising edge
- rstb  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin a BIST run; honoured in IDLE or DONE only
- pattern_en  in  NUM_PATTERNS  per-generator enable; sampled on accepted `start`
- user_addr / user_we / user_re / user_din / user_wmask  in  ADDR_WIDTH/1/1/DATA_WIDTH/MASK_WIDTH  functional port
- sram_addr / sram_we / sram_re / sram_din / sram_wmask  out  same widths  to macro
- sram_dout  in  DATA_WIDTH  macro read data
- pg_rst  out  1  active-high synchronous reset to all generators
- pg_en  out  NUM_PATTERNS  one-hot run enable
- pg_addr / pg_data / pg_check  in  NUM_PATTERNS*ADDR_WIDTH / *DATA_WIDTH / *DATA_WIDTH  flattened generator outputs; slice i belongs to generator i
- pg_wmask  in  NUM_PATTERNS*MASK_WIDTH  generator write masks
- pg_we / pg_re / pg_done  in  NUM_PATTERNS each  generator strobes
- busy  out  1  BIST owns the SRAM port
- done  out  1  run finished; held until next accepted `start`
- fail  out  1  sticky: at least one mismatch in the last run
- fail_pattern  out  $clog2(NUM_PATTERNS) (min 1)  index of first failing generator
- fail_addr  out  ADDR_WIDTH  address of first mismatch
- fail_count  out  8  mismatch count, saturates at 255

## Operation
- States:
  - IDLE: port is user-owned.
  - PGRST: `pg_rst`=1 for exactly 2 cycles.
  - RUN: `pg_en[cur]`=1; `busy`=1.
  - DRAIN: wait READ_LATENCY cycles so in-flight compares finish.
  - NEXT: select the next enabled pattern.
  - DONE: port is user-owned; `done`=1.
- Accepted `start`:
  - Latch `pattern_en`.
  - Clear `fail`, `fail_count`, `fail_pattern`, `fail_addr` and `done`.
  - Set `cur` to the lowest enabled index.
  - Go to PGRST. If no bit is enabled, go directly to DONE with `fail`=0.
- PGRST -> RUN after 2 cycles.
- RUN: SRAM port is driven combinationally from generator `cur` (addr, data, wmask, we&!done, re&!done).
- When `pg_done[cur]`=1: drop `pg_en`, issue no access that cycle, go to DRAIN.
- DRAIN -> NEXT after READ_LATENCY cycles.
- NEXT:
  - If a higher enabled index exists, it becomes `cur` and the FSM goes to PGRST, so every generator starts from reset.
  - Otherwise go to DONE.
- Compare pipeline:
  - Each forwarded read pushes {valid, check, addr, cur} into a READ_LATENCY-deep shift register.
  - At the output stage, if valid and `sram_dout` != expected, record a mismatch:
    - `fail_count` increments, saturating at 255.
    - On the first mismatch only, set `fail`=1 and capture `fail_pattern`/`fail_addr`.
- Port ownership: BIST owns the port in PGRST, RUN, DRAIN and NEXT; in those states user strobes are ignored (not queued).
- In PGRST, DRAIN and NEXT, `sram_we`=`sram_re`=0.
- `start` while `busy` is ignored.
- `pattern_en` changes mid-run are ignored.

## Timing
- Reset values: all outputs 0 (including `pg_rst`), state IDLE, pipeline empty. The user port mux is combinational, so after reset the `sram_*` outputs follow the `user_*` inputs.
- `start` accepted at edge 0: `pg_rst`=1 in cycles 1-2; RUN and the first generator access on `sram_*` in cycle 3.
- Read issued in cycle t is compared in cycle t+READ_LATENCY; mismatch state is visible from cycle t+READ_LATENCY+1.
- `pg_done` seen in cycle d: DRAIN in cycles d+1 .. d+READ_LATENCY; then NEXT for 1 cycle.
- Last pattern: `busy` falls and `done` rises in the same cycle (DONE entry).
- `rstb` low mid-run: immediate return to IDLE, port back to user, `done`=0, counters cleared.

## Test plan
- Fault-free SRAM model, `pattern_en`=3'b111, March CM-enhanced generators on 64x8, mux 4 -> `done`=1, `fail`=0, `fail_count`=0; `busy` spans exactly the three runs plus per-pattern PGRST/DRAIN/NEXT cycles.
- Stuck-at-1 on bit 3 at address 17 -> `fail`=1, `fail_pattern`=0, `fail_addr`=17, `fail_count` equals the number of reads of addr 17 expecting 0 in bit 3.
- Every read corrupted -> `fail_count` saturates at 255 and holds; `fail_addr`= first read address (0).
- `pattern_en`=3'b000 -> DONE one cycle after `start`, `fail`=0, no SRAM access; `pattern_en`=3'b100 -> only `pg_en[2]` ever asserted.
- User writes while busy: no user access reaches `sram_*`. `start` pulsed during RUN is ignored. After `done`, user write 0xA5 to addr 5 passes through on the same cycle.
- Deassert `rstb` in the middle of pattern 1 -> all outputs 0 immediately; a new `start` runs a clean full sequence.

Source files
------------

// File: rtl/bist_ctrl.sv
// Built-in self-test sequencer for one SRAM port: runs the enabled pattern generators
// back to back, compares read data after the macro latency and reports the first failure.
module bist_ctrl #(
  parameter int  ADDR_WIDTH   = 6,
  parameter int  DATA_WIDTH   = 8,
  parameter int  MASK_WIDTH   = 2,
  parameter int  NUM_PATTERNS = 3,
  parameter int  READ_LATENCY = 1,
  localparam int PAT_WIDTH    = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1
) (
  input  logic                               clk,
  input  logic                               rstb,
  input  logic                               start,
  input  logic [NUM_PATTERNS-1:0]            pattern_en,
  input  logic [ADDR_WIDTH-1:0]              user_addr,
  input  logic                               user_we,
  input  logic                               user_re,
  input  logic [DATA_WIDTH-1:0]              user_din,
  input  logic [MASK_WIDTH-1:0]              user_wmask,
  output logic [ADDR_WIDTH-1:0]              sram_addr,
  output logic                               sram_we,
  output logic                               sram_re,
  output logic [DATA_WIDTH-1:0]              sram_din,
  output logic [MASK_WIDTH-1:0]              sram_wmask,
  input  logic [DATA_WIDTH-1:0]              sram_dout,
  output logic                               pg_rst,
  output logic [NUM_PATTERNS-1:0]            pg_en,
  input  logic [NUM_PATTERNS*ADDR_WIDTH-1:0] pg_addr,
  input  logic [NUM_PATTERNS*DATA_WIDTH-1:0] pg_data,
  input  logic [NUM_PATTERNS*DATA_WIDTH-1:0] pg_check,
  input  logic [NUM_PATTERNS*MASK_WIDTH-1:0] pg_wmask,
  input  logic [NUM_PATTERNS-1:0]            pg_we,
  input  logic [NUM_PATTERNS-1:0]            pg_re,
  input  logic [NUM_PATTERNS-1:0]            pg_done,
  output logic                               busy,
  output logic                               done,
  output logic                               fail,
  output logic [PAT_WIDTH-1:0]               fail_pattern,
  output logic [ADDR_WIDTH-1:0]              fail_addr,
  output logic [7:0]                         fail_count
);

  localparam int CNT_WIDTH = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] PGRST = 3'd1;
  localparam logic [2:0] RUN   = 3'd2;
  localparam logic [2:0] DRAIN = 3'd3;
  localparam logic [2:0] NEXT  = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  logic [2:0]              state;
  logic [NUM_PATTERNS-1:0] en_lat;
  logic [PAT_WIDTH-1:0]    cur;
  logic                    rst_cnt;
  logic [CNT_WIDTH-1:0]    drain_cnt;

  logic [ADDR_WIDTH-1:0] gen_addr  [NUM_PATTERNS];
  logic [DATA_WIDTH-1:0] gen_data  [NUM_PATTERNS];
  logic [DATA_WIDTH-1:0] gen_check [NUM_PATTERNS];
  logic [MASK_WIDTH-1:0] gen_wmask [NUM_PATTERNS];

  for (genvar g = 0; g < NUM_PATTERNS; g++) begin : g_slice
    assign gen_addr[g]  = pg_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign gen_data[g]  = pg_data[g*DATA_WIDTH +: DATA_WIDTH];
    assign gen_check[g] = pg_check[g*DATA_WIDTH +: DATA_WIDTH];
    assign gen_wmask[g] = pg_wmask[g*MASK_WIDTH +: MASK_WIDTH];
  end

  logic [PAT_WIDTH-1:0] first_idx;
  logic [PAT_WIDTH-1:0] next_idx;
  logic                 next_found;

  // Lowest enabled index of the incoming request, and lowest latched index above cur.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    first_idx  = '0;
    next_idx   = '0;
    next_found = 1'b0;
    for (int i = NUM_PATTERNS - 1; i >= 0; i--) begin
      if (pattern_en[i]) first_idx = PAT_WIDTH'(i);
      if (en_lat[i] && (i > int'(cur))) begin
        next_idx   = PAT_WIDTH'(i);
        next_found = 1'b1;
      end
    end
  end

  logic start_ok;
  logic run_access;
  logic bist_re;

  assign start_ok   = start && ((state == IDLE) || (state == DONE));
  assign busy       = state inside {PGRST, RUN, DRAIN, NEXT};
  assign done       = (state == DONE);
  assign pg_rst     = (state == PGRST);
  assign run_access = (state == RUN) && !pg_done[cur];
  assign bist_re    = run_access && pg_re[cur];

  always_comb begin
    pg_en = '0;
    if (state == RUN) pg_en[cur] = 1'b1;
  end

  // While BIST owns the port, user strobes are simply dropped.
  always_comb begin
    if (busy) begin
      sram_addr  = gen_addr[cur];
      sram_din   = gen_data[cur];
      sram_wmask = gen_wmask[cur];
      sram_we    = run_access && pg_we[cur];
      sram_re    = bist_re;
    end else begin
      sram_addr  = user_addr;
      sram_din   = user_din;
      sram_wmask = user_wmask;
      sram_we    = user_we;
      sram_re    = user_re;
    end
  end

  logic                  pipe_valid [READ_LATENCY];
  logic [DATA_WIDTH-1:0] pipe_check [READ_LATENCY];
  logic [ADDR_WIDTH-1:0] pipe_addr  [READ_LATENCY];
  logic [PAT_WIDTH-1:0]  pipe_pat   [READ_LATENCY];

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int i = 0; i < READ_LATENCY; i++) pipe_valid[i] <= 1'b0;
    end else begin
      pipe_valid[0] <= bist_re;
      for (int i = 1; i < READ_LATENCY; i++) pipe_valid[i] <= pipe_valid[i-1];
    end
  end

  // NOTE: only the valid bits are reset; the payload is never looked at while invalid.
  always_ff @(posedge clk) begin
    pipe_check[0] <= gen_check[cur];
    pipe_addr[0]  <= gen_addr[cur];
    pipe_pat[0]   <= cur;
    for (int i = 1; i < READ_LATENCY; i++) begin
      pipe_check[i] <= pipe_check[i-1];
      pipe_addr[i]  <= pipe_addr[i-1];
      pipe_pat[i]   <= pipe_pat[i-1];
    end
  end

  logic cmp_mismatch;
  assign cmp_mismatch = pipe_valid[READ_LATENCY-1] &&
                        (sram_dout != pipe_check[READ_LATENCY-1]);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state        <= IDLE;
      en_lat       <= '0;
      cur          <= '0;
      rst_cnt      <= 1'b0;
      drain_cnt    <= '0;
      fail         <= 1'b0;
      fail_pattern <= '0;
      fail_addr    <= '0;
      fail_count   <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop sees pre-edge values.
      case (state)
        IDLE, DONE: begin
          if (start) begin
            en_lat  <= pattern_en;
            cur     <= first_idx;
            rst_cnt <= 1'b0;
            state   <= (|pattern_en) ? PGRST : DONE;
          end
        end
        PGRST: begin
          if (rst_cnt) begin
            rst_cnt <= 1'b0;
            state   <= RUN;
          end else begin
            rst_cnt <= 1'b1;
          end
        end
        RUN: begin
          if (pg_done[cur]) begin
            drain_cnt <= '0;
            state     <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_cnt == CNT_WIDTH'(READ_LATENCY - 1)) state <= NEXT;
          else drain_cnt <= drain_cnt + 1'b1;
        end
        NEXT: begin
          if (next_found) begin
            cur     <= next_idx;
            rst_cnt <= 1'b0;
            state   <= PGRST;
          end else begin
            state   <= DONE;
          end
        end
        default: state <= IDLE;
      endcase

      if (start_ok) begin
        fail         <= 1'b0;
        fail_pattern <= '0;
        fail_addr    <= '0;
        fail_count   <= '0;
      end else if (cmp_mismatch) begin
        if (fail_count != 8'hFF) fail_count <= fail_count + 8'd1;
        if (!fail) begin
          fail         <= 1'b1;
          fail_pattern <= pipe_pat[READ_LATENCY-1];
          fail_addr    <= pipe_addr[READ_LATENCY-1];
        end
      end
    end
  end

endmodule
